// File: rtl/fp_norm_sequencer.sv
// Multi-cycle mantissa normalizer: leading-zero count, then a left shift of at
// most STEP bits per cycle with matching exponent decrement, valid/ready on both sides.
module fp_norm_sequencer #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_zero,
    output logic              out_uflow,
    output logic              busy
);
    localparam int LZ_W = $clog2(MANT_W + 1);
    localparam int CW   = (EXP_W > LZ_W) ? EXP_W : LZ_W;

    typedef enum logic [1:0] {IDLE, CALC, SHIFT, DONE} state_t;

    state_t            state_reg, state_next;
    logic [MANT_W-1:0] mant_reg;
    logic [EXP_W-1:0]  exp_reg;
    logic [CW-1:0]     rem_reg;
    logic              zero_reg, uflow_reg;

    logic [LZ_W-1:0]   lz;
    logic [CW-1:0]     lz_ext, lim, allowed, step_amt;
    logic              mant_is_zero;

    // Scan from LSB upward so the last hit is the highest set bit.
    always_comb begin
        lz = LZ_W'(MANT_W - 1);
        for (int i = 0; i < MANT_W; i++) begin
            if (mant_reg[i]) lz = LZ_W'(MANT_W - 1 - i);
        end
    end

    always_comb begin
        mant_is_zero = (mant_reg == '0);
        lz_ext       = CW'(lz);
        lim          = (exp_reg == '0) ? '0 : CW'(exp_reg - EXP_W'(1));
        allowed      = (lz_ext < lim) ? lz_ext : lim;
        step_amt     = (rem_reg < CW'(STEP)) ? rem_reg : CW'(STEP);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (in_valid) state_next = CALC;
            CALC:  state_next = (mant_is_zero || allowed == '0) ? DONE : SHIFT;
            SHIFT: if (rem_reg <= CW'(STEP)) state_next = DONE;
            DONE:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            mant_reg  <= '0;
            exp_reg   <= '0;
            rem_reg   <= '0;
            zero_reg  <= 1'b0;
            uflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        mant_reg <= in_mant;
                        exp_reg  <= in_exp;
                    end
                end
                CALC: begin
                    rem_reg   <= allowed;
                    zero_reg  <= mant_is_zero;
                    uflow_reg <= (lz_ext > lim) && !mant_is_zero;
                    if (mant_is_zero) exp_reg <= '0;
                end
                SHIFT: begin
                    mant_reg <= mant_reg << step_amt;
                    exp_reg  <= exp_reg - EXP_W'(step_amt);
                    rem_reg  <= rem_reg - step_amt;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = (state_reg == DONE);
    assign out_mant  = mant_reg;
    assign out_exp   = exp_reg;
    assign out_zero  = zero_reg;
    assign out_uflow = uflow_reg;
endmodule

// File: tb/tb_fp_norm_sequencer.sv
// Directed bench for fp_norm_sequencer: hand-computed results, latency and handshake checks.
module tb_fp_norm_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [23:0] in_mant, out_mant;
    logic [7:0]  in_exp, out_exp;
    logic        out_zero, out_uflow, busy;

    int tests = 0;
    int fails = 0;

    fp_norm_sequencer #(.MANT_W(24), .EXP_W(8), .STEP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp),
        .out_zero(out_zero), .out_uflow(out_uflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one operand; returns after the accept edge (edge 0).
    task automatic send(input logic [23:0] m, input logic [7:0] e);
        @(negedge clk);
        in_mant  = m;
        in_exp   = e;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count edges after edge 0 until out_valid is seen; bounded.
    task automatic wait_valid(output int edges);
        edges = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (out_valid) break;
        end
        if (!out_valid) check("timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run(input string name, input logic [23:0] m, input logic [7:0] e,
                       input int lat, input logic [23:0] xm, input logic [7:0] xe,
                       input logic xz, input logic xu);
        int edges;
        send(m, e);
        wait_valid(edges);
        check({name, "_lat"}, 32'(edges), 32'(lat));
        check({name, "_mant"}, 32'(out_mant), 32'(xm));
        check({name, "_exp"}, 32'(out_exp), 32'(xe));
        check({name, "_zero"}, 32'(out_zero), 32'(xz));
        check({name, "_uflow"}, 32'(out_uflow), 32'(xu));
        if (out_ready) begin
            @(negedge clk);
            check({name, "_vdrop"}, 32'(out_valid), 32'd0);
            check({name, "_rdy"}, 32'(in_ready), 32'd1);
        end
        $display("[TB] %s mant=%06h exp=%0d -> mant=%06h exp=%0d z=%0b u=%0b lat=%0d",
                 name, m, e, out_mant, out_exp, out_zero, out_uflow, edges);
    endtask

    initial begin
        int edges;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_mant = '0; in_exp = '0;
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_mant", 32'(out_mant), 32'd0);
        check("rst_exp", 32'(out_exp), 32'd0);
        check("rst_flags", {30'd0, out_zero, out_uflow}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);

        run("t1_norm",   24'h800000, 8'd100, 1, 24'h800000, 8'd100, 1'b0, 1'b0);
        run("t2_lz23",   24'h000001, 8'd100, 7, 24'h800000, 8'd77,  1'b0, 1'b0);
        run("t3_floor",  24'h000100, 8'd5,   2, 24'h001000, 8'd1,   1'b0, 1'b1);
        run("t4_zero",   24'h000000, 8'd50,  1, 24'h000000, 8'd0,   1'b1, 1'b0);
        run("t_step4",   24'h080000, 8'd100, 2, 24'h800000, 8'd96,  1'b0, 1'b0);
        run("t_step5",   24'h040000, 8'd100, 3, 24'h800000, 8'd95,  1'b0, 1'b0);
        run("t_exp0",    24'h400000, 8'd0,   1, 24'h400000, 8'd0,   1'b0, 1'b1);
        run("t_exp1",    24'h000010, 8'd1,   1, 24'h000010, 8'd1,   1'b0, 1'b1);

        // Back-pressure: result must hold and new operands must be ignored.
        out_ready = 1'b0;
        run("t5_hold", 24'h000001, 8'd100, 7, 24'h800000, 8'd77, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_mant = 24'h123456; in_exp = 8'd9; in_valid = 1'b1;
            @(negedge clk);
            check("t5_hold_valid", 32'(out_valid), 32'd1);
            check("t5_hold_mant", 32'(out_mant), 32'h800000);
            check("t5_hold_exp", 32'(out_exp), 32'd77);
            check("t5_hold_rdy", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("t5_rel_valid", 32'(out_valid), 32'd0);
        check("t5_rel_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("t5_no_accept", 32'(busy), 32'd0);
        $display("[TB] t5_hold released, ignored operands not accepted busy=%0b", busy);

        // Reset in the middle of SHIFT.
        send(24'h000001, 8'd100);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t6_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_mant", 32'(out_mant), 32'd0);
        check("t6_exp", 32'(out_exp), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        check("t6_ready", 32'(in_ready), 32'd1);
        $display("[TB] t6_reset abort valid=%0b busy=%0b", out_valid, busy);
        run("t6_after", 24'h800000, 8'd100, 1, 24'h800000, 8'd100, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
